// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a shift register through load, N shifts (pausable/abortable) and a done pulse.
// Ports: i_clk clock; i_clr_ sync active-low reset; i_start/i_dir/i_len request; i_pause stall; i_abort cancel;
//        o_sel reg mode (00 hold,01 left,10 right,11 load); o_ready idle; o_busy active; o_shift shifting;
//        o_cnt shifts remaining; o_done completion pulse. All outputs are registered.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic          i_clk,
  input  logic          i_clr_,
  input  logic          i_start,
  input  logic          i_dir,
  input  logic [CW-1:0] i_len,
  input  logic          i_pause,
  input  logic          i_abort,
  output logic [1:0]    o_sel,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_shift,
  output logic [CW-1:0] o_cnt,
  output logic          o_done
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [CW-1:0] WMAX = CW'(WIDTH);
  state_t        state_q, state_d;
  logic          dir_q, dir_d, shift_q, shift_d;
  logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d, eff_len;
  // shift_q marks a cycle that actually shifts; SHIFT with shift_q=0 is a pause cycle.
  // i_pause seen at the end of a shift cycle turns the following cycle into a hold.
  always_comb begin
    eff_len = (i_len == '0 || i_len > WMAX) ? WMAX : i_len;
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    shift_d = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = LOAD;
        dir_d   = i_dir;
        cnt_d   = eff_len;
      end
      LOAD: begin
        state_d = i_abort ? IDLE : SHIFT;
        shift_d = !i_abort;
        cnt_d   = i_abort ? '0 : cnt_q;
      end
      SHIFT: begin
        state_d = i_abort ? IDLE : (shift_q && cnt_q == CW'(1)) ? DONE : SHIFT;
        cnt_d   = (state_d == SHIFT) ? cnt_q - CW'(shift_q) : '0;
        shift_d = (state_d == SHIFT) && !i_pause;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    sel_d   = (state_d == LOAD) ? 2'b11 : shift_d ? (dir_d ? 2'b10 : 2'b01) : 2'b00;
    ready_d = state_d == IDLE;
    busy_d  = state_d == LOAD || state_d == SHIFT;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_clr_) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      shift_q <= 1'b0;
      sel_q   <= 2'b00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sel_q   <= sel_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign o_sel   = sel_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_shift = shift_q;
  assign o_cnt   = cnt_q;
  assign o_done  = done_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for shift_seq_ctrl (directed sequences plus random soak).
module tb_shift_seq_ctrl;
  logic       i_clk, i_clr_, i_start, i_dir, i_pause, i_abort;
  logic [3:0] i_len;
  logic [1:0] o_sel;
  logic       o_ready, o_busy, o_shift, o_done;
  logic [3:0] o_cnt;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [1:0] sel;
    logic [3:0] cnt;
    logic done, ready, busy, shift;
  } exp_t;
  exp_t q[$];
  int unsigned lenq[$];
  shift_seq_ctrl #(.WIDTH(8), .CW(4)) dut (
    .i_clk(i_clk), .i_clr_(i_clr_), .i_start(i_start), .i_dir(i_dir), .i_len(i_len),
    .i_pause(i_pause), .i_abort(i_abort), .o_sel(o_sel), .o_ready(o_ready), .o_busy(o_busy),
    .o_shift(o_shift), .o_cnt(o_cnt), .o_done(o_done)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int eff(input logic [3:0] l);
    return (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
  endfunction
  function automatic exp_t mk(input logic [1:0] s, input int c, input logic d, input logic r, input logic b, input logic sh);
    exp_t e;
    e.sel = s; e.cnt = 4'(c); e.done = d; e.ready = r; e.busy = b; e.shift = sh;
    return e;
  endfunction
  function automatic exp_t idl();
    return mk(2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic exp_t ld(input int n);
    return mk(2'b11, n, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic exp_t sh(input logic d, input int c);
    return mk(d ? 2'b10 : 2'b01, c, 1'b0, 1'b0, 1'b1, 1'b1);
  endfunction
  function automatic exp_t hold(input int c);
    return mk(2'b00, c, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic exp_t dn();
    return mk(2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  task automatic drive(input logic s, input logic d, input logic [3:0] l, input logic p, input logic a, input logic c);
    i_start = s; i_dir = d; i_len = l; i_pause = p; i_abort = a; i_clr_ = c;
  endtask
  task automatic cyc();
    exp_t e;
    @(posedge i_clk);
    #1;
    if (q.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = q.pop_front();
      chk("sel", 32'(o_sel), 32'(e.sel));
      chk("cnt", 32'(o_cnt), 32'(e.cnt));
      chk("done", 32'(o_done), 32'(e.done));
      chk("ready", 32'(o_ready), 32'(e.ready));
      chk("busy", 32'(o_busy), 32'(e.busy));
      chk("shift", 32'(o_shift), 32'(e.shift));
    end
  endtask
  // One operation from IDLE; nz injects inputs that must be ignored (start/pause/abort where irrelevant, flipped dir).
  task automatic op(input logic dir, input logic [3:0] len, input int pause_at, input int pause_n,
                    input int abort_at, input int clr_at, input logic nz);
    int n, c, k;
    n = eff(len);
    drive(1'b1, dir, len, nz, nz, 1'b1); q.push_back(ld(n)); cyc();
    drive(nz, dir ^ nz, 4'd1, nz, 1'b0, 1'b1); q.push_back(sh(dir, n)); cyc();
    c = n;
    k = 1;
    forever begin
      if (k == clr_at) begin
        drive(1'b1, dir, len, 1'b1, 1'b1, 1'b0); q.push_back(idl()); cyc();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); q.push_back(idl()); cyc();
        return;
      end
      if (k == abort_at) begin
        drive(nz, dir, len, nz, 1'b1, 1'b1); q.push_back(idl()); cyc();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); q.push_back(idl()); cyc();
        return;
      end
      if (c == 1) begin
        drive(nz, dir, len, nz, 1'b0, 1'b1); q.push_back(dn()); cyc();
        drive(nz, dir, len, nz, nz, 1'b1); q.push_back(idl()); cyc();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        return;
      end
      c--;
      if (k == pause_at)
        for (int j = 0; j < pause_n; j++) begin
          drive(nz, dir, len, 1'b1, 1'b0, 1'b1); q.push_back(hold(c)); cyc();
        end
      drive(nz, dir, len, 1'b0, 1'b0, 1'b1); q.push_back(sh(dir, c)); cyc();
      k++;
    end
  endtask
  initial begin
    int shifts;
    logic s, p, a, d;
    logic [3:0] l;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0); q.push_back(idl()); cyc();
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); q.push_back(idl()); cyc();
    op(1'b0, 4'd3, 0, 0, 0, 0, 1'b0);
    op(1'b1, 4'd0, 0, 0, 0, 0, 1'b0);
    op(1'b1, 4'd15, 0, 0, 0, 0, 1'b0);
    op(1'b0, 4'd9, 0, 0, 0, 0, 1'b1);
    op(1'b0, 4'd4, 2, 2, 0, 0, 1'b0);
    op(1'b1, 4'd6, 1, 3, 0, 0, 1'b1);
    op(1'b1, 4'd5, 0, 0, 2, 0, 1'b1);
    op(1'b0, 4'd8, 0, 0, 0, 3, 1'b0);
    op(1'b1, 4'd1, 0, 0, 0, 0, 1'b1);
    op(1'b1, 4'd2, 0, 0, 0, 0, 1'b0);
    shifts = 0;
    for (int i = 0; i < 12000; i++) begin
      if (o_shift) shifts++;
      if (o_done) begin
        if (lenq.size() == 0) chk("rnd_spurious_done", 1, 0);
        else chk("rnd_shift_total", 32'(shifts), 32'(lenq.pop_front()));
      end
      chk("inv_shift", 32'(o_shift), 32'(o_sel == 2'b01 || o_sel == 2'b10));
      chk("inv_load", 32'(o_sel == 2'b11 && !o_busy), 0);
      chk("inv_done_sel", 32'(o_done && o_sel != 2'b00), 0);
      s = 1'($urandom_range(0, 1));
      p = $urandom_range(0, 2) == 0;
      a = $urandom_range(0, 39) == 0;
      d = 1'($urandom_range(0, 1));
      l = 4'($urandom_range(0, 15));
      if (o_ready && s) begin
        lenq.push_back(32'(eff(l)));
        shifts = 0;
      end else if (o_busy && a && lenq.size() != 0) void'(lenq.pop_front());
      drive(s, d, l, p, a, 1'b1);
      @(posedge i_clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the controlled shift register and the maximum shift count.
REQ-002 SHALL have parameter CW, default 4: width of the shift-length and count fields; it SHALL hold the value WIDTH.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_clr_, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port i_start, input, 1: operation request, sampled only while o_ready=1.
REQ-006 SHALL have port i_dir, input, 1: shift direction, 0 = left, 1 = right; latched at accept.
REQ-007 SHALL have port i_len, input, CW: number of shifts; latched at accept.
REQ-008 SHALL have port i_pause, input, 1: stall shifting while high.
REQ-009 SHALL have port i_abort, input, 1: cancel the operation in progress.
REQ-010 SHALL have port o_sel, output, 2: shift-register mode (00 hold, 01 shift left, 10 shift right, 11 load).
REQ-011 SHALL have port o_ready, output, 1: idle and able to accept i_start.
REQ-012 SHALL have port o_busy, output, 1: operation in progress (LOAD or SHIFT state).
REQ-013 SHALL have port o_shift, output, 1: high in each cycle where o_sel is 01 or 10.
REQ-014 SHALL have port o_cnt, output, CW: shifts remaining.
REQ-015 SHALL have port o_done, output, 1: single-cycle completion pulse.

Function
REQ-016 SHALL implement the states IDLE, LOAD, SHIFT and DONE.
REQ-017 SHALL drive all outputs from registered state only, with no combinational input-to-output path.
REQ-018 In IDLE: o_sel=00, o_ready=1, o_busy=0; on i_start=1 SHALL latch i_dir and the effective length and go to LOAD.
REQ-019 Effective length: i_len=0 SHALL map to WIDTH, and i_len>WIDTH SHALL clamp to WIDTH.
REQ-020 In LOAD (exactly one cycle): o_sel=11, o_busy=1, o_cnt=effective length; next state SHALL be SHIFT.
REQ-021 In SHIFT with i_pause=0: o_sel SHALL be 10 if the latched dir=1, else 01; o_shift=1.
REQ-022 In SHIFT with i_pause=0: o_cnt SHALL decrement by 1 per cycle.
REQ-023 In SHIFT with i_pause=0: the cycle where o_cnt=1 SHALL be the last shift, with next state DONE.
REQ-024 In SHIFT with i_pause=1: o_sel=00, o_shift=0, o_cnt held, state held; pausing any number of cycles SHALL NOT change the total shift count.
REQ-025 i_pause SHALL be ignored in IDLE, LOAD and DONE.
REQ-026 In DONE (exactly one cycle): o_done=1, o_sel=00, o_cnt=0, o_busy=0; next state SHALL be IDLE.
REQ-027 Latency with no pause: i_start accepted at edge t gives LOAD in cycle t+1, N shift cycles t+2..t+1+N, o_done in cycle t+2+N, and o_ready in cycle t+3+N.
REQ-028 i_start SHALL be ignored outside IDLE; back-to-back operations therefore have a minimum period of N+3 cycles.
REQ-029 i_abort=1 in LOAD or SHIFT SHALL force IDLE at the next edge with o_cnt=0 and no o_done pulse.
REQ-030 i_abort SHALL be ignored in IDLE and DONE.
REQ-031 Simultaneous i_abort and i_pause: abort SHALL win.
REQ-032 Simultaneous i_start and i_abort in IDLE: start SHALL be accepted.
REQ-033 o_sel SHALL never be 11 outside LOAD, and never 01 or 10 outside SHIFT.

Reset
REQ-034 i_clr_=0 at a rising edge SHALL force IDLE from any state, including mid-shift.
REQ-035 Reset values SHALL be: o_sel=00, o_ready=1, o_busy=0, o_shift=0, o_cnt=0, o_done=0, latched dir=0.
REQ-036 Reset SHALL take priority over i_start, i_abort and i_pause.
REQ-037 No o_done pulse SHALL follow a reset.

Verification
REQ-038 Start, dir=0, len=3, no pause -> o_sel 11,01,01,01,00; o_cnt 3,2,1,0; o_done in cycle t+5; o_ready in cycle t+6.
REQ-039 Start, dir=1, len=0 -> exactly 8 cycles of o_sel=10, then o_done; repeat with len=15 -> also 8 shifts.
REQ-040 len=4 with i_pause high for 2 cycles after the 2nd shift -> 2 cycles of o_sel=00 with o_cnt held at 2, then 2 more shifts, for 4 o_shift pulses total.
REQ-041 i_abort in the 2nd shift cycle of len=5 -> IDLE next cycle, o_cnt=0, no o_done; i_start pulsed during the operation has no effect.
REQ-042 i_clr_=0 in the 3rd shift cycle, with i_start also high -> next cycle all outputs at reset values, o_ready=1, no o_done.
REQ-043 Random start/pause/abort for at least 10k cycles -> o_shift pulses per completed operation equal the effective length, and the REQ-033 invariant holds in every cycle.
